// File: rtl/data_bank_pkg.sv
// data_bank_pkg: shared sizes and state/mode types for the data bank reader.
// No ports.
package data_bank_pkg;
    localparam int NUM_WORDS = 4;
    localparam int ADDR_W    = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_e;
    typedef enum logic {BURST = 1'b0, SINGLE = 1'b1} mode_e;
endpackage

// File: rtl/data_bank_snapshot.sv
// data_bank_snapshot: 4-word shadow copy of the bank with a combinational read port.
// Ports: i_clk, i_rst_n (async active-low), i_load_all (copy every word),
//        i_load_one/i_load_idx (copy one word), i_bank (live words),
//        i_rd_idx/o_rd_data (read port).
module data_bank_snapshot
    import data_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_all,
    input  logic              i_load_one,
    input  logic [ADDR_W-1:0] i_load_idx,
    input  logic [WIDTH-1:0]  i_bank [NUM_WORDS],
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [WIDTH-1:0]  o_rd_data
);
    logic [WIDTH-1:0] r_shadow [NUM_WORDS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_WORDS; k++) r_shadow[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_WORDS; k++)
                if (i_load_all || (i_load_one && i_load_idx == ADDR_W'(k)))
                    r_shadow[k] <= i_bank[k];
        end
    end

    assign o_rd_data = r_shadow[i_rd_idx];
endmodule

// File: rtl/data_bank_reader.sv
// data_bank_reader: snapshots the 4-word bank and streams it out over valid/ready,
// or returns one word by address.
// Ports: i_clk, i_rst_n (async active-low), i_bank0..3 (live words),
//        i_start (burst request), i_rd_req/i_rd_addr (single read),
//        o_dout/o_dout_addr/o_dout_valid/o_dout_last with i_dout_ready (beat stream),
//        o_busy (SEND or DONE), o_done (one-cycle completion pulse).
// Build option: DATA_BANK_READER_CHECKSUM_EN appends a sum-of-words beat to bursts.
module data_bank_reader
    import data_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_bank0,
    input  logic [WIDTH-1:0]  i_bank1,
    input  logic [WIDTH-1:0]  i_bank2,
    input  logic [WIDTH-1:0]  i_bank3,
    input  logic              i_start,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_dout,
    output logic [ADDR_W-1:0] o_dout_addr,
    output logic              o_dout_valid,
    input  logic              i_dout_ready,
    output logic              o_dout_last,
    output logic              o_busy,
    output logic              o_done
);
    state_e            r_state;
    mode_e             r_mode;
    logic [ADDR_W-1:0] r_idx;
    logic [WIDTH-1:0]  w_bank [NUM_WORDS];
    logic [WIDTH-1:0]  w_rd_data;
    logic [WIDTH-1:0]  w_data;
    logic              w_start;
    logic              w_rd;
    logic              w_xfer;
    logic              w_last;

    assign w_bank[0] = i_bank0;
    assign w_bank[1] = i_bank1;
    assign w_bank[2] = i_bank2;
    assign w_bank[3] = i_bank3;

    // start has priority; a simultaneous rd_req is simply dropped
    assign w_start = r_state == IDLE && i_start;
    assign w_rd    = r_state == IDLE && !i_start && i_rd_req;
    assign w_xfer  = r_state == SEND && i_dout_ready;

    data_bank_snapshot #(.WIDTH(WIDTH)) u_snapshot (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load_all (w_start),
        .i_load_one (w_rd),
        .i_load_idx (i_rd_addr),
        .i_bank     (w_bank),
        .i_rd_idx   (r_idx),
        .o_rd_data  (w_rd_data)
    );

`ifdef DATA_BANK_READER_CHECKSUM_EN
    logic             r_csum_beat;
    logic [WIDTH-1:0] r_sum;

    // Sum accumulates as the data beats are accepted, so by the time idx wraps
    // to 0 for the extra beat it already holds all four shadow words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum_beat <= 1'b0;
            r_sum       <= '0;
        end else if (w_start) begin
            r_csum_beat <= 1'b0;
            r_sum       <= '0;
        end else if (w_xfer && r_mode == BURST && !r_csum_beat) begin
            r_sum       <= r_sum + w_rd_data;
            r_csum_beat <= r_idx == ADDR_W'(NUM_WORDS - 1);
        end else if (w_xfer) begin
            r_csum_beat <= 1'b0;
        end
    end

    assign w_last = r_csum_beat || r_mode == SINGLE;
    assign w_data = r_csum_beat ? r_sum : w_rd_data;
`else
    assign w_last = r_mode == SINGLE || r_idx == ADDR_W'(NUM_WORDS - 1);
    assign w_data = w_rd_data;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_mode  <= BURST;
            r_idx   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= SEND;
                        r_mode  <= BURST;
                        r_idx   <= '0;
                    end else if (w_rd) begin
                        r_state <= SEND;
                        r_mode  <= SINGLE;
                        r_idx   <= i_rd_addr;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_last) r_state <= DONE;
                        else        r_idx   <= r_idx + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_dout_valid = r_state == SEND;
    assign o_busy       = r_state != IDLE;
    assign o_done       = r_state == DONE;
    assign o_dout       = o_dout_valid ? w_data : '0;
    assign o_dout_addr  = o_dout_valid ? r_idx : '0;
    assign o_dout_last  = o_dout_valid && w_last;
endmodule
